bird_motion_ctrl: RTL and testbench

BIRD_MOTION_CTRL -- requirements
Module: bird_motion_ctrl

---
 rtl/bird_motion_ctrl_if.sv | 31 +++
 rtl/bird_motion_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bird_motion_ctrl_if.sv
// Game-side connection of the bird motion controller: flap and game state in,
// sprite position, animation and collision pulses out.
interface bird_motion_ctrl_if;
  logic        flap;
  logic [3:0]  game_state;
  logic [31:0] birdY;
  logic [1:0]  bird_state;
  logic [1:0]  bird_angle;
  logic        hit_floor;
  logic        hit_ceiling;

  modport master (
    output flap,
    output game_state,
    input  birdY,
    input  bird_state,
    input  bird_angle,
    input  hit_floor,
    input  hit_ceiling
  );

  modport slave (
    input  flap,
    input  game_state,
    output birdY,
    output bird_state,
    output bird_angle,
    output hit_floor,
    output hit_ceiling
  );
endinterface

// File: rtl/bird_motion_ctrl.sv
// Fixed-point vertical physics for the bird sprite: gravity, flap impulse, floor/ceiling
// clamping, freeze on pause, start-screen hover autopilot and wing/tilt animation state.
module bird_motion_ctrl #(
  parameter int unsigned BIRD_SIZE_Y = 24,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned GRAVITY     = 40,
  parameter int unsigned FLAP_VEL    = 1024,
  parameter int unsigned V_TERM      = 1536,
  parameter int unsigned HOVER_Y     = 250,
  parameter int unsigned ANIM_TICKS  = 64
) (
  input logic               clk,
  input logic               rst_n,
  bird_motion_ctrl_if.slave bus
);

  localparam int unsigned PW  = 16 + FRAC_BITS;
  localparam int unsigned IW  = PW - FRAC_BITS;
  localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  localparam logic signed [PW-1:0] SMAX       = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN       = {1'b1, {(PW-1){1'b0}}};
  localparam logic signed [PW-1:0] FLOOR_POS  = PW'((SCREEN_H - BIRD_SIZE_Y) << FRAC_BITS);
  localparam logic signed [PW-1:0] CENTER_POS = PW'(((SCREEN_H - BIRD_SIZE_Y) / 2) << FRAC_BITS);
  localparam logic signed [PW-1:0] GRAV_V     = PW'(GRAVITY);
  localparam logic signed [PW-1:0] FLAP_V     = PW'(FLAP_VEL);
  localparam logic signed [PW-1:0] VTERM_V    = PW'(V_TERM);
  localparam logic signed [PW-1:0] VHALF_V    = PW'(V_TERM / 2);

  localparam logic [3:0] GS_START = 4'b0001;
  localparam logic [3:0] GS_GAME  = 4'b0010;

  localparam logic [1:0] FLAP_1    = 2'd0;
  localparam logic [1:0] FLAP_2    = 2'd1;
  localparam logic [1:0] FLAP_3    = 2'd2;
  localparam logic [1:0] ANG_HORZ  = 2'd0;
  localparam logic [1:0] ANG_POS45 = 2'd1;
  localparam logic [1:0] ANG_NEG45 = 2'd2;

  typedef enum logic [1:0] {ST_RUN, ST_FROZEN, ST_GROUNDED} state_t;

  state_t                r_state;
  logic signed [PW-1:0]  r_pos;
  logic signed [PW-1:0]  r_vel;
  logic [TCW-1:0]        r_tick_cnt;
  logic [ACW-1:0]        r_anim_cnt;
  logic                  r_pending;
  logic                  r_flap_prev;
  logic [3:0]            r_gs_prev;
  logic [1:0]            r_bird_state;
  logic [1:0]            r_angle;
  logic                  r_hit_floor;
  logic                  r_hit_ceiling;

  logic                  w_is_start;
  logic                  w_is_game;
  logic                  w_gs_run;
  logic                  w_start_entry;
  logic                  w_flap_edge;
  logic                  w_tick;
  logic                  w_autoflap;
  logic                  w_do_flap;
  logic signed [PW-1:0]  w_vel_grav;
  logic signed [PW-1:0]  w_vel_new;
  logic signed [PW-1:0]  w_pos_sum;

  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                   input logic signed [PW-1:0] b);
    logic [PW:0] s;
    s = {a[PW-1], a} + {b[PW-1], b};
    if (s[PW] != s[PW-1]) return s[PW] ? SMIN : SMAX;
    return s[PW-1:0];
  endfunction

  function automatic logic [1:0] angle_of(input logic signed [PW-1:0] v);
    if (v[PW-1]) return ANG_NEG45;
    if (v >= VHALF_V) return ANG_POS45;
    return ANG_HORZ;
  endfunction

  // Game-state decode and the candidate physics step for the current tick
  always_comb begin
    w_is_start    = (bus.game_state == GS_START);
    w_is_game     = (bus.game_state == GS_GAME);
    w_gs_run      = w_is_start || w_is_game;
    w_start_entry = w_is_start && (r_gs_prev != GS_START);
    w_flap_edge   = bus.flap && !r_flap_prev;
    w_tick        = (r_tick_cnt == TCW'(TICK_DIV - 1));
    w_autoflap    = w_is_start && (r_pos[PW-1:FRAC_BITS] > IW'(HOVER_Y)) && !r_vel[PW-1];
    w_do_flap     = r_pending || w_flap_edge || w_autoflap;
    w_vel_grav    = sat_add(r_vel, GRAV_V);
    if (w_vel_grav > VTERM_V) w_vel_grav = VTERM_V;
    w_vel_new     = w_do_flap ? -FLAP_V : w_vel_grav;
    w_pos_sum     = sat_add(r_pos, w_vel_new);
  end

  // Motion state machine; non-running states simply leave the physics registers untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pos         <= CENTER_POS;
      r_vel         <= '0;
      r_tick_cnt    <= '0;
      r_anim_cnt    <= '0;
      r_pending     <= 1'b0;
      r_flap_prev   <= 1'b0;
      r_gs_prev     <= GS_START;
      r_bird_state  <= FLAP_1;
      r_angle       <= ANG_HORZ;
      r_hit_floor   <= 1'b0;
      r_hit_ceiling <= 1'b0;
    end else begin
      r_flap_prev   <= bus.flap;
      r_gs_prev     <= bus.game_state;
      r_hit_floor   <= 1'b0;
      r_hit_ceiling <= 1'b0;
      if (w_start_entry) begin
        r_state      <= ST_RUN;
        r_pos        <= CENTER_POS;
        r_vel        <= '0;
        r_pending    <= 1'b0;
        r_tick_cnt   <= '0;
        r_anim_cnt   <= '0;
        r_bird_state <= FLAP_1;
        r_angle      <= ANG_HORZ;
      end else if (r_state == ST_GROUNDED) begin
        r_state <= ST_GROUNDED;
      end else if (!w_gs_run) begin
        r_state <= ST_FROZEN;
      end else begin
        r_state <= ST_RUN;
        if (w_tick) begin
          r_tick_cnt <= '0;
          r_pending  <= 1'b0;
          if (w_pos_sum[PW-1]) begin
            r_pos         <= '0;
            r_vel         <= '0;
            r_angle       <= ANG_HORZ;
            r_bird_state  <= FLAP_1;
            r_anim_cnt    <= '0;
            r_hit_ceiling <= 1'b1;
          end else if (w_pos_sum >= FLOOR_POS) begin
            r_pos        <= FLOOR_POS;
            r_vel        <= '0;
            r_angle      <= ANG_HORZ;
            r_bird_state <= FLAP_1;
            r_anim_cnt   <= '0;
            if (w_is_game) begin
              r_hit_floor <= 1'b1;
              r_state     <= ST_GROUNDED;
            end
          end else begin
            r_pos   <= w_pos_sum;
            r_vel   <= w_vel_new;
            r_angle <= angle_of(w_vel_new);
            if (!w_vel_new[PW-1]) begin
              r_bird_state <= FLAP_1;
              r_anim_cnt   <= '0;
            end else if (w_do_flap) begin
              r_bird_state <= FLAP_2;
              r_anim_cnt   <= '0;
            end else if (r_anim_cnt == ACW'(ANIM_TICKS - 1)) begin
              r_bird_state <= (r_bird_state == FLAP_2) ? FLAP_3 : FLAP_2;
              r_anim_cnt   <= '0;
            end else begin
              r_anim_cnt <= r_anim_cnt + ACW'(1);
            end
          end
        end else begin
          r_tick_cnt <= r_tick_cnt + TCW'(1);
          if (w_flap_edge) r_pending <= 1'b1;
        end
      end
    end
  end

  assign bus.birdY       = 32'(r_pos[PW-1:FRAC_BITS]);
  assign bus.bird_state  = r_bird_state;
  assign bus.bird_angle  = r_angle;
  assign bus.hit_floor   = r_hit_floor;
  assign bus.hit_ceiling = r_hit_ceiling;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with a short physics tick (TICK_DIV = 4).
module tb_bird_motion_ctrl;

  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  bird_motion_ctrl_if bus();

  bird_motion_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ang(input int v);
    if (v < 0) return 32'd2;
    if (v >= 768) return 32'd1;
    return 32'd0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    int vel;
    int mx;
    int mn;
    int nfl;
    logic [31:0] ey;
    logic [31:0] ea;
    logic [31:0] es;
    logic [31:0] ec;
    bit fl;

    // Reset values
    rst_n = 1'b0;
    bus.flap = 1'b0;
    bus.game_state = 4'b0010;
    repeat (3) @(negedge clk);
    chk("rst_birdY", bus.birdY, 32'd228);
    chk("rst_state", 32'(bus.bird_state), 32'd0);
    chk("rst_angle", 32'(bus.bird_angle), 32'd0);
    chk("rst_hit_floor", 32'(bus.hit_floor), 32'd0);
    chk("rst_hit_ceiling", 32'(bus.hit_ceiling), 32'd0);

    // Free fall in game until the floor
    rst_n = 1'b1;
    pos = 58368;
    vel = 0;
    for (int n = 1; n <= 57; n++) begin
      cyc(4);
      vel = (vel + 40 > 1536) ? 1536 : vel + 40;
      pos = pos + vel;
      fl = 1'b0;
      if (pos >= 116736) begin
        pos = 116736;
        vel = 0;
        fl = 1'b1;
      end
      chk($sformatf("fall_y[%0d]", n), bus.birdY, 32'(pos / 256));
      chk($sformatf("fall_angle[%0d]", n), 32'(bus.bird_angle), ang(vel));
      chk($sformatf("fall_hit_floor[%0d]", n), 32'(bus.hit_floor), 32'(fl));
    end
    chk("floor_y", bus.birdY, 32'd456);
    cyc(1);
    chk("floor_pulse_end", 32'(bus.hit_floor), 32'd0);

    // Grounded: flap ignored, no further floor pulses
    nfl = 0;
    bus.flap = 1'b1;
    cyc(1);
    bus.flap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      nfl += int'(bus.hit_floor);
    end
    chk("grounded_no_repulse", 32'(nfl), 32'd0);
    chk("grounded_y", bus.birdY, 32'd456);
    chk("grounded_angle", 32'(bus.bird_angle), 32'd0);

    // Reset while grounded takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", bus.birdY, 32'd228);
    chk("async_rst_state", 32'(bus.bird_state), 32'd0);
    chk("async_rst_angle", 32'(bus.bird_angle), 32'd0);

    // Flap right after release; a second edge before the tick must collapse into it
    @(negedge clk);
    rst_n = 1'b1;
    bus.flap = 1'b1;
    cyc(1);
    bus.flap = 1'b0;
    cyc(1);
    bus.flap = 1'b1;
    cyc(1);
    bus.flap = 1'b0;
    chk("pre_tick_y", bus.birdY, 32'd228);
    chk("pre_tick_angle", 32'(bus.bird_angle), 32'd0);
    cyc(1);
    chk("flap_y", bus.birdY, 32'd224);
    chk("flap_angle", 32'(bus.bird_angle), 32'd2);
    chk("flap_state", 32'(bus.bird_state), 32'd1);
    cyc(4);
    chk("collapse_y", bus.birdY, 32'd220);

    // Flap every tick until clamped at the ceiling
    for (int k = 1; k <= 56; k++) begin
      bus.flap = 1'b1;
      cyc(1);
      bus.flap = 1'b0;
      cyc(3);
      if (k < 56) begin
        ey = 32'((56360 - 1024 * k) / 256);
        ea = 32'd2;
        es = 32'd1;
        ec = 32'd0;
      end else begin
        ey = 32'd0;
        ea = 32'd0;
        es = 32'd0;
        ec = 32'd1;
      end
      chk($sformatf("ceil_y[%0d]", k), bus.birdY, ey);
      chk($sformatf("ceil_angle[%0d]", k), 32'(bus.bird_angle), ea);
      chk($sformatf("ceil_state[%0d]", k), 32'(bus.bird_state), es);
      chk($sformatf("ceil_hit[%0d]", k), 32'(bus.hit_ceiling), ec);
    end
    cyc(1);
    chk("ceil_pulse_end", 32'(bus.hit_ceiling), 32'd0);
    cyc(3);
    chk("ceil_hold_y", bus.birdY, 32'd0);
    chk("ceil_hold_angle", 32'(bus.bird_angle), 32'd0);
    cyc(12);
    chk("gravity_y", bus.birdY, 32'd1);

    // Flap edge, then pause and an illegal game_state mid-tick
    bus.flap = 1'b1;
    cyc(1);
    bus.flap = 1'b0;
    bus.game_state = 4'b0100;
    cyc(500);
    bus.game_state = 4'b0110;
    cyc(500);
    chk("pause_y", bus.birdY, 32'd1);
    bus.game_state = 4'b0010;
    cyc(2);
    chk("resume_phase_y", bus.birdY, 32'd1);
    chk("resume_phase_ceil", 32'(bus.hit_ceiling), 32'd0);
    cyc(1);
    chk("resume_flap_y", bus.birdY, 32'd0);
    chk("resume_flap_ceil", 32'(bus.hit_ceiling), 32'd1);

    // End screen freezes, start screen re-centres and hovers
    bus.game_state = 4'b1000;
    cyc(10);
    chk("end_frozen_y", bus.birdY, 32'd0);
    bus.game_state = 4'b0001;
    cyc(1);
    chk("start_y", bus.birdY, 32'd228);
    chk("start_angle", 32'(bus.bird_angle), 32'd0);
    chk("start_state", 32'(bus.bird_state), 32'd0);
    cyc(64);
    chk("auto_t16_y", bus.birdY, 32'd249);
    cyc(4);
    chk("auto_t17_y", bus.birdY, 32'd251);
    cyc(4);
    chk("auto_t18_y", bus.birdY, 32'd247);
    chk("auto_t18_angle", 32'(bus.bird_angle), 32'd2);
    chk("auto_t18_state", 32'(bus.bird_state), 32'd1);
    mx = 0;
    mn = 1000;
    nfl = 0;
    for (int i = 0; i < 2400; i++) begin
      cyc(1);
      if (int'(bus.birdY) > mx) mx = int'(bus.birdY);
      if (int'(bus.birdY) < mn) mn = int'(bus.birdY);
      nfl += int'(bus.hit_floor);
    end
    chk("auto_max_in_band", 32'(mx >= 251 && mx <= 256), 32'd1);
    chk("auto_min_rises", 32'(mn < 228), 32'd1);
    chk("auto_no_floor", 32'(nfl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
